sha256_msg_schedule: RTL and testbench

Upstream feeder for the SHA-256 compression stage. Accepts one 512-bit padded message block and emits the 64 round words W[t] with the matching round constant K[t], one pair per cycle. Also emits the round index, a per-word valid strobe and an end-of-block pulse. Words 16..63 are expanded on the fly in a 16-word sliding window; no 64-word storage.

---
 rtl/sha256_pkg.sv | 41 ++++
 rtl/sha256_k_rom.sv | 13 +
 rtl/sha256_msg_schedule.sv | 140 ++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: constants and helper functions shared by the SHA-256 message
// schedule and the compression-side models.
//   WORD_W      - SHA-256 word width (32)
//   ROUND_COUNT - rounds per block (64)
//   K_TABLE     - the 64 round constants
//   small_sigma0 / small_sigma1 - message-expansion sigma functions
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int ROUND_COUNT = 64;

    localparam logic [WORD_W-1:0] K_TABLE [ROUND_COUNT] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // s0(x) = ror7 ^ ror18 ^ shr3
    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // s1(x) = ror17 ^ ror19 ^ shr10
    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: combinational lookup of the SHA-256 round constant.
//   addr - round index 0..63
//   k    - K[addr]
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]        addr,
    output logic [WORD_W-1:0] k
);

    assign k = K_TABLE[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: emits W[t] and K[t] for t = 0..63 of one 512-bit block,
// one pair per cycle, expanding words 16..63 in a 16-word sliding window.
//   clk, rst  - clock, asynchronous active-high reset
//   start     - load block_in (accepted in IDLE and DONE only)
//   block_in  - padded block, M0 in bits [511:480]
//   hold      - downstream stall, freezes the schedule while in RUN
//   busy      - block in flight, capture through done cycle
//   w_rdy     - W/K/round valid
//   W, K      - round word and round constant
//   round     - round index of W/K
//   done      - one-cycle pulse after round 63
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUND_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [511:0]      block_in,
    input  logic              hold,
    output logic              busy,
    output logic              w_rdy,
    output logic [WORD_W-1:0] W,
    output logic [WORD_W-1:0] K,
    output logic [5:0]        round,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    logic [1:0]        state;
    // The window always holds the next 16 words to emit, head first:
    // win[0] = w[t], win[15] = w[t+15].
    logic [WORD_W-1:0] win     [16];
    logic [WORD_W-1:0] src_win [16];
    logic [WORD_W-1:0] new_word;
    logic [5:0]        next_round;
    logic [WORD_W-1:0] k_next;
    logic              capture;
    logic              last;
    logic              emit;

    // Capture and emit decisions plus the window source selection.
    always_comb begin
        capture = start && ((state == ST_IDLE) || (state == ST_DONE));
        last    = (round == LAST_ROUND);
        emit    = capture || ((state == ST_RUN) && !hold && !last);
        // On capture the block itself is the window, so W0 and its
        // expansion leave on the same edge as the load.
        for (int i = 0; i < 16; i++) begin
            if (capture) begin
                src_win[i] = block_in[511 - 32*i -: 32];
            end else begin
                src_win[i] = win[i];
            end
        end
        // w[t+16] = s1(w[t+14]) + w[t+9] + s0(w[t+1]) + w[t]; words past 63
        // are computed but never emitted.
        new_word = small_sigma1(src_win[14]) + src_win[9]
                 + small_sigma0(src_win[1]) + src_win[0];
        if (capture) begin
            next_round = 6'd0;
        end else begin
            next_round = round + 6'd1;
        end
    end

    sha256_k_rom u_k_rom (
        .addr (next_round),
        .k    (k_next)
    );

    // Schedule state, sliding window and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'h0000_0000;
            end
            round <= 6'd0;
            W     <= 32'h0000_0000;
            K     <= 32'h0000_0000;
            w_rdy <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (emit) begin
                W     <= src_win[0];
                K     <= k_next;
                round <= next_round;
                for (int i = 0; i < 15; i++) begin
                    win[i] <= src_win[i+1];
                end
                win[15] <= new_word;
            end
            w_rdy <= emit;
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (capture) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy <= 1'b1;
                    if (!hold && last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (capture) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: directed and random blocks checked
// against a plain-arithmetic SHA-256 message schedule model.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic         hold;
    logic         busy;
    logic         w_rdy;
    logic [31:0]  W;
    logic [31:0]  K;
    logic [5:0]   round;
    logic         done;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] KREF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    sha256_msg_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .hold     (hold),
        .busy     (busy),
        .w_rdy    (w_rdy),
        .W        (W),
        .K        (K),
        .round    (round),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule: the textbook 64-entry array expansion.
    task automatic build_expected(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[511 - 32*t -: 32];
            end else begin
                exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Follows one block from the start edge (start already driven by the
    // caller at a negedge) up to its done pulse, sampling at negedges.
    // mode 0: no hold, 1: 3-cycle holds at rounds 5 and 40, 2: random hold,
    // 3: stray start at round 20, 4: asynchronous reset at round 30.
    task automatic run_block(input logic [511:0] blk, input int mode, output int done_cyc);
        int  idx = 0;
        int  cyc = 0;
        int  nhold = 0;
        int  hcnt = 0;
        bit  t_a = 0;
        bit  t_b = 0;
        bit  fin = 0;
        build_expected(blk);
        done_cyc = -1;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk("first_w_rdy", 32'(w_rdy), 32'd1);
            chk("done_with_w_rdy", 32'(done & w_rdy), 32'd0);
            chk("busy_with_w_rdy", 32'(!w_rdy || busy), 32'd1);
            if (w_rdy) begin
                if (idx < 64) begin
                    chk($sformatf("W[%0d]", idx), W, exp_w[idx]);
                    chk($sformatf("K[%0d]", idx), K, KREF[idx]);
                    chk($sformatf("round[%0d]", idx), 32'(round), 32'(idx));
                    obs_w[idx] = W;
                    obs_k[idx] = K;
                end else begin
                    chk("extra_word", 32'(idx), 32'd63);
                end
                idx++;
            end else if (!done && idx > 0) begin
                chk("round_frozen", 32'(round), 32'(idx - 1));
                chk("w_frozen", W, exp_w[idx - 1]);
            end
            if (done) begin
                fin = 1;
                done_cyc = cyc;
                chk("word_count", 32'(idx), 32'd64);
                chk("busy_on_done", 32'(busy), 32'd1);
                chk("done_latency", 32'(cyc), 32'(65 + nhold));
            end else if (mode == 4 && idx == 30) begin
                #2 rst = 1'b1;
                #1;
                chk("arst_W", W, 32'd0);
                chk("arst_K", K, 32'd0);
                chk("arst_round", 32'(round), 32'd0);
                chk("arst_flags", {29'd0, busy, w_rdy, done}, 32'd0);
                hold = 1'b0;
                fin = 1;
            end else begin
                hold = 1'b0;
                if (mode == 1) begin
                    if (hcnt == 0 && idx == 5 && !t_a) begin hcnt = 3; t_a = 1; end
                    if (hcnt == 0 && idx == 40 && !t_b) begin hcnt = 3; t_b = 1; end
                    if (hcnt > 0) begin hold = 1'b1; hcnt--; end
                end else if (mode == 2) begin
                    hold = ($urandom_range(0, 15) == 0);
                end else if (mode == 3 && idx == 20 && !t_a) begin
                    start = 1'b1;
                    block_in = ~blk;
                    t_a = 1;
                end
                if (hold) nhold++;
            end
        end
        if (!fin) chk("timeout_no_done", 32'(cyc), 32'd0);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] blk;
        int d0;
        int d1;
        int d;
        abc = {32'h61626380, 448'd0, 32'h00000018};
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        block_in = 512'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_W", W, 32'd0);
        chk("rst_K", K, 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_flags", {29'd0, busy, w_rdy, done}, 32'd0);
        rst = 1'b0;
        hold = 1'b1;                    // hold in IDLE must not matter
        @(negedge clk);
        chk("idle_flags", {29'd0, busy, w_rdy, done}, 32'd0);
        hold = 1'b0;

        // "abc" block, no stall
        block_in = abc;
        start = 1'b1;
        run_block(abc, 0, d0);
        chk("abc_W0", obs_w[0], 32'h61626380);
        chk("abc_W15", obs_w[15], 32'h00000018);
        chk("abc_W16", obs_w[16], 32'h61626380);
        chk("abc_W17", obs_w[17], 32'h000F0000);
        chk("abc_K0", obs_k[0], 32'h428a2f98);
        chk("abc_K63", obs_k[63], 32'hc67178f2);
        @(negedge clk);
        chk("idle_after_done", {29'd0, busy, w_rdy, done}, 32'd0);

        // Same block with holds at rounds 5 and 40
        block_in = abc;
        start = 1'b1;
        run_block(abc, 1, d1);
        chk("hold_done_delay", 32'(d1 - d0), 32'd6);
        @(negedge clk);

        // Stray start in RUN
        block_in = abc;
        start = 1'b1;
        run_block(abc, 3, d);
        @(negedge clk);

        // Back-to-back: second start in the DONE cycle
        blk = rand_block();
        block_in = blk;
        start = 1'b1;
        run_block(blk, 0, d);
        blk = rand_block();
        block_in = blk;
        start = 1'b1;
        run_block(blk, 0, d);
        @(negedge clk);

        // Asynchronous reset mid-block, then a clean block
        blk = rand_block();
        block_in = blk;
        start = 1'b1;
        run_block(blk, 4, d);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {29'd0, busy, w_rdy, done}, 32'd0);
        end
        blk = rand_block();
        block_in = blk;
        start = 1'b1;
        run_block(blk, 0, d);

        // Random blocks with random hold, issued back-to-back
        for (int n = 0; n < 1000; n++) begin
            blk = rand_block();
            block_in = blk;
            start = 1'b1;
            run_block(blk, 2, d);
        end
        start = 1'b0;
        hold = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
